// File: rtl/cpu_defs.sv
// Shared CPU constants: register-file geometry and writeback-select encodings.
package cpu_defs;

  localparam int REG_NUM  = 32;
  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC4 = 2'd2
  } wd_sel_e;

endpackage

// File: rtl/reg_file_read_port.sv
// One GRF read port: forces index 0 to zero and optionally forwards same-cycle write data.
module reg_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] a,
  input  logic [ADDR_W-1:0] a3,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] rd
);

  // With forwarding disabled the write-side inputs are intentionally ignored.
  logic unused_fwd;
  assign unused_fwd = ^{wd, a3, reg_write};

  always_comb begin
    rd = stored;
    if (a == '0)
      rd = '0;
    else if ((BYPASS != 0) && reg_write && (a3 == a))
      rd = wd;
  end

endmodule

// File: rtl/reg_file.sv
// MIPS general-purpose register file with commit counter.
// Define GRF_TRACE_EN to print a grader-format line for every attempted write.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Reg_Write,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD,
  input  logic [31:0]       PC,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [31:0]       Write_Count
);
  import cpu_defs::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;
  logic              fwd_en;

  assign commit = Reg_Write && (A3 != ADDR_W'(REG_ZERO));
  // Registers read zero while in reset, so forwarding must be suppressed there too.
  assign fwd_en = Reg_Write && !Reset;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      Write_Count <= '0;
    end else if (commit) begin
      regs[A3]    <= WD;
      Write_Count <= Write_Count + 32'd1;
    end
  end

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rp1 (
    .a(A1), .a3(A3), .reg_write(fwd_en), .wd(WD), .stored(regs[A1]), .rd(RD1)
  );

  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rp2 (
    .a(A2), .a3(A3), .reg_write(fwd_en), .wd(WD), .stored(regs[A2]), .rd(RD2)
  );

`ifdef GRF_TRACE_EN
  always @(posedge Clk) begin
    if (!Reset && (Reg_Write === 1'b1))
      $display("@%h: $%d <= %h", PC, A3, WD);
  end
`else
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: forwarding and non-forwarding builds side by side.
module tb_reg_file;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Reg_Write;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD, PC;
  logic [31:0] RD1, RD2, Write_Count;
  logic [31:0] RD1_nb, RD2_nb, Write_Count_nb;

  int n_vec = 0;
  int n_err = 0;

  // Reference: plain array of architectural registers plus a commit tally.
  logic [31:0] model [32];
  logic [31:0] cnt;

  always #5 Clk = ~Clk;

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .Clk(Clk), .Reset(Reset), .Reg_Write(Reg_Write), .A1(A1), .A2(A2), .A3(A3),
    .WD(WD), .PC(PC), .RD1(RD1), .RD2(RD2), .Write_Count(Write_Count)
  );

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Reset(Reset), .Reg_Write(Reg_Write), .A1(A1), .A2(A2), .A3(A3),
    .WD(WD), .PC(PC), .RD1(RD1_nb), .RD2(RD2_nb), .Write_Count(Write_Count_nb)
  );

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    cnt = 32'h0;
  endtask

  // Commit one write cycle (or an idle cycle when we=0) to both DUTs and the model.
  task automatic clock_write(input logic we, input logic [4:0] a3, input logic [31:0] wd);
    Reg_Write = we; A3 = a3; WD = wd; PC = PC + 32'd4;
    @(posedge Clk);
    if (we && a3 != 5'd0) begin
      model[a3] = wd;
      cnt = cnt + 32'd1;
    end
    #1;
    Reg_Write = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 Reset = 1'b1;
    #2 Reset = 1'b0;
    model_clear();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Reg_Write = 1'b0; A1 = 0; A2 = 0; A3 = 0; WD = 0; PC = 32'h3000;
    model_clear();
    #3;
    n_vec++;
    if (Write_Count !== 32'h0 || Write_Count_nb !== 32'h0) begin
      n_err++;
      $display("FAIL reset_count: got %h/%h want 0", Write_Count, Write_Count_nb);
    end
    // Forwarding must not leak through during reset.
    Reg_Write = 1'b1; A3 = 5'd9; WD = 32'hCAFEF00D; A1 = 5'd9; A2 = 5'd9; #1;
    n_vec++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_nofwd: got %h/%h want 0", RD1, RD2);
    end
    @(posedge Clk); #1;
    Reg_Write = 1'b0;
    #2 Reset = 1'b0;
    @(posedge Clk); #1;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i); #1;
      n_vec++;
      if (RD1 !== 32'h0 || RD2 !== 32'h0 || RD1_nb !== 32'h0 || RD2_nb !== 32'h0) begin
        n_err++;
        $display("FAIL reset_read[%0d]: got %h %h %h %h want 0", i, RD1, RD2, RD1_nb, RD2_nb);
      end
    end
  endtask

  task automatic test_basic();
    clock_write(1'b1, 5'd5, 32'h12345678);
    A1 = 5'd5; #1;
    n_vec++;
    if (RD1 !== 32'h12345678 || RD1_nb !== 32'h12345678 || Write_Count !== 32'd1) begin
      n_err++;
      $display("FAIL basic_write: got %h %h cnt %0d want 12345678 cnt 1", RD1, RD1_nb, Write_Count);
    end
    clock_write(1'b0, 5'd5, 32'hFFFFFFFF);
    A1 = 5'd5; #1;
    n_vec++;
    if (RD1 !== 32'h12345678 || RD1_nb !== 32'h12345678 || Write_Count !== 32'd1) begin
      n_err++;
      $display("FAIL basic_hold: got %h %h cnt %0d want 12345678 cnt 1", RD1, RD1_nb, Write_Count);
    end
  endtask

  task automatic test_zero_reg();
    A1 = 5'd0; A2 = 5'd0;
    Reg_Write = 1'b1; A3 = 5'd0; WD = 32'hDEADBEEF; #1;
    n_vec++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
      n_err++;
      $display("FAIL zero_nofwd: got %h/%h want 0", RD1, RD2);
    end
    clock_write(1'b1, 5'd0, 32'hDEADBEEF);
    n_vec++;
    if (RD1 !== 32'h0 || RD1_nb !== 32'h0 || Write_Count !== cnt || Write_Count_nb !== cnt) begin
      n_err++;
      $display("FAIL zero_write: got %h %h cnt %0d want 0 cnt %0d", RD1, RD1_nb, Write_Count, cnt);
    end
  endtask

  task automatic test_bypass();
    clock_write(1'b1, 5'd31, 32'h1);
    A1 = 5'd31; A2 = 5'd31;
    Reg_Write = 1'b1; A3 = 5'd31; WD = 32'h00003008; #1;
    n_vec++;
    if (RD1 !== 32'h00003008 || RD2 !== 32'h00003008) begin
      n_err++;
      $display("FAIL bypass_fwd: got %h/%h want 00003008", RD1, RD2);
    end
    n_vec++;
    if (RD1_nb !== 32'h1 || RD2_nb !== 32'h1) begin
      n_err++;
      $display("FAIL bypass_off_pre: got %h/%h want 00000001", RD1_nb, RD2_nb);
    end
    clock_write(1'b1, 5'd31, 32'h00003008);
    n_vec++;
    if (RD1_nb !== 32'h00003008 || RD2_nb !== 32'h00003008 || RD1 !== 32'h00003008) begin
      n_err++;
      $display("FAIL bypass_post: got %h/%h/%h want 00003008", RD1_nb, RD2_nb, RD1);
    end
  endtask

  task automatic test_collision();
    clock_write(1'b1, 5'd7, 32'h11111111);
    Reg_Write = 1'b1; A3 = 5'd7; WD = 32'hA5A5A5A5;
    #2 Reset = 1'b1;
    @(posedge Clk);
    #2 Reset = 1'b0;
    Reg_Write = 1'b0;
    model_clear();
    A1 = 5'd7; A2 = 5'd7; #1;
    n_vec++;
    if (RD1 !== 32'h0 || RD2_nb !== 32'h0 || Write_Count !== 32'h0 || Write_Count_nb !== 32'h0) begin
      n_err++;
      $display("FAIL collision: got %h %h cnt %0d/%0d want 0 cnt 0", RD1, RD2_nb, Write_Count, Write_Count_nb);
    end
  endtask

  task automatic test_sweep();
    pulse_reset();
    for (int i = 1; i < 32; i++)
      clock_write(1'b1, 5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(i); #1;
      n_vec++;
      if (RD1 !== 32'(i) * 32'h01010101 || RD2 !== 32'(i) * 32'h01010101 ||
          RD1_nb !== 32'(i) * 32'h01010101 || RD2_nb !== 32'(i) * 32'h01010101) begin
        n_err++;
        $display("FAIL sweep[%0d]: got %h %h %h %h want %h", i, RD1, RD2, RD1_nb, RD2_nb,
                 32'(i) * 32'h01010101);
      end
    end
    n_vec++;
    if (Write_Count !== 32'd31 || Write_Count_nb !== 32'd31) begin
      n_err++;
      $display("FAIL sweep_count: got %0d/%0d want 31", Write_Count, Write_Count_nb);
    end
  endtask

  task automatic test_random();
    logic        we;
    logic [4:0]  a1, a2, a3;
    logic [31:0] wd, e1, e2;
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 3) != 0);
      a3 = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      wd = $urandom;
      A1 = a1; A2 = a2; Reg_Write = we; A3 = a3; WD = wd; #1;
      e1 = (we && a3 != 0 && a1 == a3) ? wd : model[a1];
      e2 = (we && a3 != 0 && a2 == a3) ? wd : model[a2];
      n_vec++;
      if (RD1 !== e1 || RD2 !== e2) begin
        n_err++;
        $display("FAIL rand_fwd[%0d]: got %h/%h want %h/%h", n, RD1, RD2, e1, e2);
      end
      n_vec++;
      if (RD1_nb !== model[a1] || RD2_nb !== model[a2]) begin
        n_err++;
        $display("FAIL rand_nofwd[%0d]: got %h/%h want %h/%h", n, RD1_nb, RD2_nb, model[a1], model[a2]);
      end
      clock_write(we, a3, wd);
      n_vec++;
      if (Write_Count !== cnt || Write_Count_nb !== cnt) begin
        n_err++;
        $display("FAIL rand_count[%0d]: got %0d/%0d want %0d", n, Write_Count, Write_Count_nb, cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    #2 Reset = 1'b1;
    model_clear();
    #1;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(i); #1;
      n_vec++;
      if (RD1 !== 32'h0 || RD2 !== 32'h0 || RD1_nb !== 32'h0 || Write_Count !== 32'h0) begin
        n_err++;
        $display("FAIL midreset[%0d]: got %h %h %h cnt %0d want 0", i, RD1, RD2, RD1_nb, Write_Count);
      end
    end
    Reset = 1'b0;
    clock_write(1'b0, 5'd3, 32'h77777777);
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i); #1;
      n_vec++;
      if (RD1 !== 32'h0 || RD2 !== 32'h0 || RD2_nb !== 32'h0) begin
        n_err++;
        $display("FAIL postreset[%0d]: got %h %h %h want 0", i, RD1, RD2, RD2_nb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_reg();
    test_bypass();
    test_collision();
    test_sweep();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
